// File: rtl/core_inst_sequencer.sv
// Tile-level instruction sequencer for the weight-stationary core: loads weights,
// streams activations, executes, then drains the OFIFO into output SRAM.
module core_inst_sequencer #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int ADDR_BW = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] w_base,
  input  logic [ADDR_BW-1:0] x_base,
  input  logic [ADDR_BW-1:0] o_base,
  input  logic [ADDR_BW-1:0] num_act,
  input  logic               acc_en,
  input  logic               ofifo_valid,
  output logic [52:0]        inst,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int CNT_BW = ADDR_BW + 1;
  localparam int TO_BW  = $clog2(TIMEOUT + 1);

  localparam logic [52:0] IDLE_WORD = 53'h0006_0001_800C_0000;

  localparam int B_CEN_OMEM  = 50;
  localparam int B_WEN_OMEM  = 49;
  localparam int B_A_OMEM_LO = 38;
  localparam int B_MODE      = 35;
  localparam int B_DATA_MODE = 34;
  localparam int B_ACC       = 33;
  localparam int B_CEN_PMEM  = 32;
  localparam int B_A_PMEM_LO = 20;
  localparam int B_CEN_XMEM  = 19;
  localparam int B_A_XMEM_LO = 7;
  localparam int B_OFIFO_RD  = 6;
  localparam int B_L0_RD     = 3;
  localparam int B_L0_WR     = 2;
  localparam int B_EXECUTE   = 1;
  localparam int B_LOAD      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_LOAD,
    ST_W_KERN,
    ST_W_FLUSH,
    ST_A_LOAD,
    ST_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic [TO_BW-1:0]   idle_cnt_q, idle_cnt_d;
  logic               drain_wr_q, drain_wr_d;
  logic [ADDR_BW-1:0] w_base_q, w_base_d;
  logic [ADDR_BW-1:0] x_base_q, x_base_d;
  logic [ADDR_BW-1:0] o_base_q, o_base_d;
  logic [CNT_BW-1:0]  num_act_q, num_act_d;
  logic               acc_en_q, acc_en_d;
  logic [52:0]        inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;

  // The instruction word is computed from the current state/counter and registered,
  // so every field reaches the core one cycle after the state that produced it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idle_cnt_d    = idle_cnt_q;
    drain_wr_d    = drain_wr_q;
    w_base_d      = w_base_q;
    x_base_d      = x_base_q;
    o_base_d      = o_base_q;
    num_act_d     = num_act_q;
    acc_en_d      = acc_en_q;
    timeout_err_d = timeout_err_q;
    done_d        = 1'b0;
    inst_d        = IDLE_WORD;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_W_LOAD;
          cnt_d         = '0;
          idle_cnt_d    = '0;
          drain_wr_d    = 1'b0;
          w_base_d      = w_base;
          x_base_d      = x_base;
          o_base_d      = o_base;
          num_act_d     = {1'b0, num_act};
          acc_en_d      = acc_en;
          timeout_err_d = 1'b0;
        end
      end

      ST_W_LOAD: begin
        inst_d[B_MODE]      = 1'b1;
        inst_d[B_DATA_MODE] = 1'b1;
        if (cnt_q < CNT_BW'(ROW)) begin
          inst_d[B_CEN_PMEM] = 1'b0;
          inst_d[B_A_PMEM_LO +: ADDR_BW] = w_base_q + cnt_q[ADDR_BW-1:0];
        end
        // SRAM data arrives one cycle after its address, so l0_wr trails by one.
        if (cnt_q != '0) inst_d[B_L0_WR] = 1'b1;
        if (cnt_q == CNT_BW'(ROW)) begin
          state_d = ST_W_KERN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      ST_W_KERN: begin
        inst_d[B_MODE]  = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
        if (cnt_q == CNT_BW'(COL - 1)) begin
          state_d = ST_W_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      ST_W_FLUSH: begin
        inst_d[B_MODE] = 1'b1;
        if (cnt_q == CNT_BW'(ROW + COL - 1)) begin
          cnt_d   = '0;
          state_d = (num_act_q == '0) ? ST_DONE : ST_A_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      ST_A_LOAD: begin
        inst_d[B_MODE] = 1'b1;
        if (cnt_q < num_act_q) begin
          inst_d[B_CEN_XMEM] = 1'b0;
          inst_d[B_A_XMEM_LO +: ADDR_BW] = x_base_q + cnt_q[ADDR_BW-1:0];
        end
        if (cnt_q != '0) inst_d[B_L0_WR] = 1'b1;
        if (cnt_q == num_act_q) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      ST_EXEC: begin
        inst_d[B_MODE]    = 1'b1;
        inst_d[B_L0_RD]   = 1'b1;
        inst_d[B_EXECUTE] = 1'b1;
        inst_d[B_ACC]     = acc_en_q;
        if (cnt_q == num_act_q - CNT_BW'(1)) begin
          state_d    = ST_DRAIN;
          cnt_d      = '0;
          idle_cnt_d = '0;
          drain_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      ST_DRAIN: begin
        inst_d[B_MODE] = 1'b1;
        idle_cnt_d = ofifo_valid ? '0 : idle_cnt_q + TO_BW'(1);
        // Read and write slots alternate, so an OFIFO pop is never back-to-back.
        if (drain_wr_q) begin
          inst_d[B_CEN_OMEM] = 1'b0;
          inst_d[B_WEN_OMEM] = 1'b0;
          inst_d[B_A_OMEM_LO +: ADDR_BW] = o_base_q + cnt_q[ADDR_BW-1:0];
          cnt_d      = cnt_q + CNT_BW'(1);
          drain_wr_d = 1'b0;
          if (cnt_q + CNT_BW'(1) == num_act_q) state_d = ST_DONE;
        end else if (ofifo_valid) begin
          inst_d[B_OFIFO_RD] = 1'b1;
          drain_wr_d         = 1'b1;
        end else if (idle_cnt_q == TO_BW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end
      end

      ST_DONE: begin
        inst_d[B_MODE] = 1'b1;
        done_d         = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idle_cnt_q    <= '0;
      drain_wr_q    <= 1'b0;
      w_base_q      <= '0;
      x_base_q      <= '0;
      o_base_q      <= '0;
      num_act_q     <= '0;
      acc_en_q      <= 1'b0;
      inst_q        <= IDLE_WORD;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      drain_wr_q    <= drain_wr_d;
      w_base_q      <= w_base_d;
      x_base_q      <= x_base_d;
      o_base_q      <= o_base_d;
      num_act_q     <= num_act_d;
      acc_en_q      <= acc_en_d;
      inst_q        <= inst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign inst        = inst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Scoreboard bench for core_inst_sequencer: the stimulus side builds the expected
// instruction timeline per tile, a monitor pops and compares it every cycle.
module tb_core_inst_sequencer;

  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int ADDR_BW = 11;
  localparam int TIMEOUT = 1024;

  localparam logic [52:0] IDLE_WORD = 53'h0006_0001_800C_0000;
  localparam logic [52:0] MODE_WORD = IDLE_WORD | 53'h0000_0008_0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ADDR_BW-1:0] w_base, x_base, o_base, num_act;
  logic               acc_en;
  logic               ofifo_valid;
  logic [52:0]        inst;
  logic               busy, done, timeout_err;

  int checks = 0;
  int errors = 0;
  int valid_mode = 0;

  logic [52:0]        exp_word_q[$];
  logic [ADDR_BW-1:0] exp_omem_q[$];
  int                 tile_q[$];

  typedef enum int {PH_NONE, PH_FIXED, PH_DRAIN, PH_DONE} phase_e;
  phase_e ph = PH_NONE;

  always #5 clk = ~clk;

  core_inst_sequencer #(
    .ROW(ROW), .COL(COL), .ADDR_BW(ADDR_BW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .o_base(o_base), .num_act(num_act),
    .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string name, input logic [52:0] e_inst,
                             input logic e_busy, input logic e_done, input logic e_terr);
    checks++;
    if ({inst, busy, done, timeout_err} !== {e_inst, e_busy, e_done, e_terr}) begin
      errors++;
      $display("[TB] FAIL %s t=%0t inst=%h want=%h busy=%b want=%b done=%b want=%b timeout_err=%b want=%b",
               name, $time, inst, e_inst, busy, e_busy, done, e_done, timeout_err, e_terr);
    end
  endtask

  // Expected timeline: weights, kernel load, flush, activations, execute, then drain addresses.
  task automatic applyStimulus(input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] xb,
                               input logic [ADDR_BW-1:0] ob, input logic [ADDR_BW-1:0] na,
                               input logic acc);
    logic [52:0] w;
    for (int k = 0; k <= ROW; k++) begin
      w = MODE_WORD;
      w[34] = 1'b1;
      if (k < ROW) begin
        w[32] = 1'b0;
        w[30:20] = wb + ADDR_BW'(k);
      end
      if (k >= 1) w[2] = 1'b1;
      exp_word_q.push_back(w);
    end
    for (int k = 0; k < COL; k++) begin
      w = MODE_WORD;
      w[3] = 1'b1;
      w[0] = 1'b1;
      exp_word_q.push_back(w);
    end
    for (int k = 0; k < ROW + COL; k++) exp_word_q.push_back(MODE_WORD);
    if (na != 0) begin
      for (int k = 0; k <= int'(na); k++) begin
        w = MODE_WORD;
        if (k < int'(na)) begin
          w[19] = 1'b0;
          w[17:7] = xb + ADDR_BW'(k);
        end
        if (k >= 1) w[2] = 1'b1;
        exp_word_q.push_back(w);
      end
      for (int k = 0; k < int'(na); k++) begin
        w = MODE_WORD;
        w[3] = 1'b1;
        w[1] = 1'b1;
        w[33] = acc;
        exp_word_q.push_back(w);
      end
      for (int k = 0; k < int'(na); k++) exp_omem_q.push_back(ob + ADDR_BW'(k));
    end
    w_base  = wb;
    x_base  = xb;
    o_base  = ob;
    num_act = na;
    acc_en  = acc;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tile_q.push_back(1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", IDLE_WORD, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s done=0 after %0d cycles want done=1", name, budget);
      doReset();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ofifo_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (valid_mode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = 1'($urandom_range(0, 1));
        default: ofifo_valid = 1'b0;
      endcase
    end
  end

  // Monitor: drain slots follow the sampled ofifo_valid; a pop is always followed by a write.
  initial begin : monitor
    logic               prev_valid;
    logic               exp_wr;
    logic               exp_terr;
    int                 low_run;
    logic [52:0]        w;
    prev_valid = 1'b0;
    exp_wr     = 1'b0;
    exp_terr   = 1'b0;
    low_run    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_word_q.delete();
        exp_omem_q.delete();
        tile_q.delete();
        ph       = PH_NONE;
        exp_terr = 1'b0;
      end else begin
        case (ph)
          PH_NONE: begin
            if (tile_q.size() > 0) begin
              void'(tile_q.pop_front());
              exp_terr = 1'b0;
              checkOutput("start_accept", IDLE_WORD, 1'b1, 1'b0, 1'b0);
              ph = PH_FIXED;
            end else begin
              checkOutput("idle", IDLE_WORD, 1'b0, 1'b0, exp_terr);
            end
          end
          PH_FIXED: begin
            if (exp_word_q.size() == 0) begin
              ph = PH_NONE;
            end else begin
              w = exp_word_q.pop_front();
              checkOutput("tile_word", w, 1'b1, 1'b0, exp_terr);
              if (exp_word_q.size() == 0) begin
                ph      = (exp_omem_q.size() == 0) ? PH_DONE : PH_DRAIN;
                exp_wr  = 1'b0;
                low_run = 0;
              end
            end
          end
          PH_DRAIN: begin
            w = MODE_WORD;
            if (exp_wr) begin
              w[50] = 1'b0;
              w[49] = 1'b0;
              w[48:38] = exp_omem_q.pop_front();
              exp_wr  = 1'b0;
              low_run = prev_valid ? 0 : low_run + 1;
              if (exp_omem_q.size() == 0) ph = PH_DONE;
            end else if (prev_valid) begin
              w[6]    = 1'b1;
              exp_wr  = 1'b1;
              low_run = 0;
            end else begin
              low_run++;
              if (low_run == TIMEOUT) begin
                exp_terr = 1'b1;
                exp_omem_q.delete();
                ph = PH_DONE;
              end
            end
            checkOutput("drain_word", w, 1'b1, 1'b0, exp_terr);
          end
          default: begin
            checkOutput("done_word", MODE_WORD, 1'b0, 1'b1, exp_terr);
            ph = PH_NONE;
          end
        endcase
      end
      prev_valid = ofifo_valid;
    end
  end

  initial begin
    logic [ADDR_BW-1:0] na;
    reset   = 1'b1;
    start   = 1'b0;
    w_base  = '0;
    x_base  = '0;
    o_base  = '0;
    num_act = '0;
    acc_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("power_on_reset", IDLE_WORD, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic tile, ofifo_valid tied high");
    valid_mode = 0;
    applyStimulus(11'd0, 11'd16, 11'd64, 11'd4, 1'b1);
    waitDone("basic_done", 3000);

    $display("[TB] num_act=0 tile");
    applyStimulus(11'd5, 11'd30, 11'd40, 11'd0, 1'b0);
    waitDone("zero_act_done", 3000);

    $display("[TB] address wrap with random ofifo_valid");
    valid_mode = 1;
    applyStimulus(11'd2044, 11'd2046, 11'd2045, 11'd5, 1'b0);
    waitDone("wrap_done", 3000);

    $display("[TB] reset during EXEC");
    valid_mode = 0;
    applyStimulus(11'd100, 11'd200, 11'd300, 11'd20, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    doReset();
    applyStimulus(11'd7, 11'd9, 11'd11, 11'd3, 1'b1);
    waitDone("post_reset_done", 3000);

    $display("[TB] drain timeout");
    valid_mode = 2;
    applyStimulus(11'd1, 11'd2, 11'd3, 11'd3, 1'b0);
    waitDone("timeout_done", 3000);
    valid_mode = 0;
    applyStimulus(11'd20, 11'd21, 11'd22, 11'd2, 1'b0);
    waitDone("after_timeout_done", 3000);

    $display("[TB] start pulse during EXEC is ignored");
    valid_mode = 1;
    applyStimulus(11'd50, 11'd60, 11'd70, 11'd10, 1'b1);
    repeat (48) @(posedge clk);
    #1;
    w_base  = 11'd999;
    x_base  = 11'd888;
    o_base  = 11'd777;
    num_act = 11'd1;
    acc_en  = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("ignored_start_done", 3000);

    $display("[TB] random tiles");
    for (int i = 0; i < 6; i++) begin
      valid_mode = int'($urandom_range(0, 1));
      na = ADDR_BW'($urandom_range(1, 12));
      applyStimulus(ADDR_BW'($urandom_range(0, 2047)), ADDR_BW'($urandom_range(0, 2047)),
                    ADDR_BW'($urandom_range(0, 2047)), na, 1'($urandom_range(0, 1)));
      waitDone("random_done", 3000);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_word_q.size() != 0 || exp_omem_q.size() != 0 || tile_q.size() != 0 || ph != PH_NONE) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty words=%0d omem=%0d tiles=%0d want all 0",
               exp_word_q.size(), exp_omem_q.size(), tile_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
